seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
//   Multi-cycle unsigned shift-add multiplier that produces a 2N-bit product for the
//   downstream enabled 32-bit holding register. It drives that register directly:
//   z -> register d, done -> register enable.
//   It is the datapath's low-area multiply unit, used where a one-cycle array
//   multiplier is too large.
// PARAMETERS
//   N        16   operand width in bits; product width is 2*N (32 at default)
// PORTS
//   clk      in   1     single clock, all state updates on posedge
//   rst_n    in   1     asynchronous, active-low reset
//   start    in   1     request a multiply; sampled on posedge
//   a        in   N     multiplicand, unsigned; captured when start is accepted
//   b        in   N     multiplier, unsigned; captured when start is accepted
//   z        out  2N    product; held stable between completions
//   busy     out  1     high while a multiply is in progress
//   done     out  1     one-cycle completion strobe; drives downstream enable
// BEHAVIOUR
//   Clocking and reset
//   - One clock (clk).
//   - Reset is asynchronous and active-low (rst_n). Asserting rst_n=0 at any time,
//     including mid-operation, immediately forces: state=IDLE, z=0, busy=0, done=0,
//     count=0, internal accumulator and shifters=0.
//   State machine: IDLE, RUN, DONE
//   - IDLE : start=1 at an edge -> capture a and b, clear the accumulator,
//     count=0, go to RUN. Otherwise stay in IDLE.
//   - RUN  : each edge performs one step, then count increments:
//       if mcand_lsb then acc += mcplier << count
//       (equivalently: shift the multiplier left and the multiplicand right).
//     When count reaches N-1 at an edge: z <= final acc, go to DONE.
//   - DONE : lasts exactly one cycle with done=1.
//       start=1 at this edge -> new operands captured, go to RUN (back-to-back).
//       start=0              -> go to IDLE.
//   Outputs
//   - busy = (state==RUN); combinational decode of registered state.
//   - done = (state==DONE).
//   - Latency: start sampled at edge T0 -> busy high over cycles T0..T0+N;
//     done high exactly between edges T0+N and T0+N+1; z valid from edge T0+N on.
//   - Fixed latency of N steps; no early exit for zero operands.
//   Width and arithmetic
//   - Accumulator is 2N bits, so overflow is impossible: (2^N-1)^2 < 2^2N.
//   - count is $clog2(N) bits.
//   - Unsigned only.
//   Boundary conditions
//   - start while in RUN is ignored: no re-capture, no effect on the result.
//   - a and b may change freely after the capture edge.
//   - z changes only at the completion edge or on reset. It keeps the last product
//     through IDLE and through the following RUN.
// STRUCTURE
//   - Shared include (mul_defs.vh): state encodings ST_IDLE=2'd0, ST_RUN=2'd1,
//     ST_DONE=2'd2; default N.
//   - One natural sub-module, shift_add_step: combinational single-step
//     (acc, mcand, mplier -> next acc, next mcand, next mplier).
//   - The top level holds the FSM, count, operand registers and the z register.
// TESTING
//   - rst_n=0 then 1, no start -> z=0, busy=0, done=0 held for 20 cycles.
//   - a=3, b=5, start pulse -> busy for 16 cycles; done for exactly 1 cycle;
//     z=32'd15 from the done cycle onward.
//   - a=16'hFFFF, b=16'hFFFF -> z=32'hFFFE0001. a=0, b=16'h1234 -> z=0, still
//     16-cycle latency.
//   - Start 7*9; at cycle 5 pulse start with a=2, b=2 -> ignored; z=63.
//   - start held high through DONE, with a=6, b=7 presented at the DONE edge ->
//     second run begins with no IDLE gap; z=42 exactly 17 cycles after the
//     first done.
//   - rst_n low at cycle 8 of 100*200 -> outputs 0 asynchronously. After release,
//     start 4*4 -> z=16, done once.

Source files
------------

// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encodings
// and default operand width.
package seq_multiplier_pkg;

    localparam int MUL_N_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/seq_multiplier_shift_add_step.sv
// One combinational shift-add step: conditionally add the shifted multiplier
// into the accumulator, then advance both shifters.
module shift_add_step #(
    parameter int N = 16
) (
    input  logic [2*N-1:0] acc,
    input  logic [N-1:0]   mcand,
    input  logic [2*N-1:0] mplier,
    output logic [2*N-1:0] acc_nxt,
    output logic [N-1:0]   mcand_nxt,
    output logic [2*N-1:0] mplier_nxt
);

    always_comb begin
        acc_nxt    = mcand[0] ? (acc + mplier) : acc;
        mcand_nxt  = mcand >> 1;
        mplier_nxt = mplier << 1;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle unsigned shift-add multiplier: N steps per product, 2N-bit result
// held in z and qualified by a one-cycle done strobe.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int N = MUL_N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] z,
    output logic           busy,
    output logic           done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    mul_state_e     state_q,  state_d;
    logic [CW-1:0]  count_q,  count_d;
    logic [2*N-1:0] acc_q,    acc_d;
    logic [N-1:0]   mcand_q,  mcand_d;
    logic [2*N-1:0] mplier_q, mplier_d;
    logic [2*N-1:0] z_q,      z_d;

    logic [2*N-1:0] step_acc;
    logic [N-1:0]   step_mcand;
    logic [2*N-1:0] step_mplier;

    shift_add_step #(.N(N)) u_step (
        .acc        (acc_q),
        .mcand      (mcand_q),
        .mplier     (mplier_q),
        .acc_nxt    (step_acc),
        .mcand_nxt  (step_mcand),
        .mplier_nxt (step_mplier)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        z_d      = z_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = {{N{1'b0}}, b};
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // start is deliberately not looked at here: operands stay as captured
                acc_d    = step_acc;
                mcand_d  = step_mcand;
                mplier_d = step_mplier;
                count_d  = count_q + 1'b1;
                if (count_q == LAST) begin
                    z_d     = step_acc;
                    count_d = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = {{N{1'b0}}, b};
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            z_q      <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            z_q      <= z_d;
        end
    end

    assign z    = z_q;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: vector table plus hand-written multi-cycle
// sequences (ignored start, back-to-back, asynchronous reset).
module tb_seq_multiplier;

    localparam int N = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [N-1:0]   a = '0;
    logic [N-1:0]   b = '0;
    logic [2*N-1:0] z;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] z;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    seq_multiplier #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .z     (z),
        .busy  (busy),
        .done  (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one multiply and follow it to completion. If intr >= 0, a
    // competing start (2*2) is pulsed that many cycles into the run.
    task automatic run_mul(input logic [N-1:0] ra, input logic [N-1:0] rb,
                           input logic [2*N-1:0] exp, input int intr, input string tag);
        int c;
        int bc;
        c  = 0;
        bc = 0;
        a = ra;
        b = rb;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
        while (!done && c < 40) begin
            if (busy) bc++;
            if (c == intr) begin
                start = 1'b1;
                a = 16'd2;
                b = 16'd2;
            end
            tick();
            start = 1'b0;
            c++;
        end
        check({tag, "_latency"}, 64'(c), 64'd16);
        check({tag, "_busy_cycles"}, 64'(bc), 64'd16);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_z"}, 64'(z), 64'(exp));
        tick();
        check({tag, "_done_drop"}, 64'(done), 64'd0);
        check({tag, "_z_hold"}, 64'(z), 64'(exp));
    endtask

    initial begin
        int c;
        int dcnt;

        vecs[0] = '{16'd3,     16'd5,     32'd15};
        vecs[1] = '{16'hFFFF,  16'hFFFF,  32'hFFFE0001};
        vecs[2] = '{16'd0,     16'h1234,  32'd0};
        vecs[3] = '{16'h1234,  16'd0,     32'd0};
        vecs[4] = '{16'd1,     16'hFFFF,  32'h0000FFFF};
        vecs[5] = '{16'h8000,  16'h8000,  32'h40000000};
        vecs[6] = '{16'hAAAA,  16'd3,     32'h0001FFFE};
        vecs[7] = '{16'd1000,  16'd1000,  32'd1000000};
        vecs[8] = '{16'h00FF,  16'h0101,  32'h0000FFFF};

        // Reset state, then idle with no start
        repeat (3) tick();
        check("rst_z", 64'(z), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("idle%0d_z", i), 64'(z), 64'd0);
            check($sformatf("idle%0d_busy", i), 64'(busy), 64'd0);
            check($sformatf("idle%0d_done", i), 64'(done), 64'd0);
        end

        for (int i = 0; i < 9; i++)
            run_mul(vecs[i].a, vecs[i].b, vecs[i].z, -1, $sformatf("vec%0d", i));

        // Start during RUN must be ignored
        run_mul(16'd7, 16'd9, 32'd63, 5, "ignore_start");

        // Back-to-back: start held through DONE, no IDLE gap
        a = 16'd3;
        b = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (!done && c < 40) begin
            tick();
            c++;
        end
        check("b2b_first_done", 64'(done), 64'd1);
        check("b2b_first_z", 64'(z), 64'd15);
        a = 16'd6;
        b = 16'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 16'd0;
        b = 16'd0;
        c = 1;
        check("b2b_busy_no_gap", 64'(busy), 64'd1);
        check("b2b_z_held_in_run", 64'(z), 64'd15);
        while (!done && c < 40) begin
            tick();
            c++;
        end
        check("b2b_gap", 64'(c), 64'd17);
        check("b2b_second_z", 64'(z), 64'd42);
        tick();
        check("b2b_idle_after", 64'(done), 64'd0);

        // Asynchronous reset mid-operation
        a = 16'd100;
        b = 16'd200;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_done", 64'(done), 64'd0);
        check("async_rst_z", 64'(z), 64'd0);
        tick();
        check("rst_held_z", 64'(z), 64'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", 64'(busy), 64'd0);
        run_mul(16'd4, 16'd4, 32'd16, -1, "post_rst");
        dcnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) dcnt++;
        end
        check("post_rst_done_once", 64'(dcnt), 64'd0);
        check("post_rst_z_final", 64'(z), 64'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
